// File: rtl/axis_beat_packer.sv
// axis_beat_packer: AXI-Stream width upsizer.
// Packs RATIO consecutive DATAW-bit beats into one DATAW*RATIO-bit word. A TLAST beat flushes
// a partial word early, and TKEEP marks the lanes that hold received beats. The output is
// fully registered; with downstream always ready, one word leaves every RATIO input beats
// with no bubbles.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   AXIS_S_*            narrow input stream (TVALID/TREADY/TDATA/TLAST/TID/TUSER/TDEST)
//   AXIS_M_*            wide output stream (TVALID/TREADY/TDATA/TKEEP/TLAST/TID/TUSER/TDEST)
//                       TID/TDEST come from the first beat of a word, TUSER from the last
//   SIDEBAND_ERR        one-cycle pulse when TID/TDEST changes inside a word
module axis_beat_packer #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned RATIO = 4,
  parameter int unsigned IDW   = 4,
  parameter int unsigned USERW = 4,
  parameter int unsigned DESTW = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   AXIS_S_TVALID,
  output logic                   AXIS_S_TREADY,
  input  logic [DATAW-1:0]       AXIS_S_TDATA,
  input  logic                   AXIS_S_TLAST,
  input  logic [IDW-1:0]         AXIS_S_TID,
  input  logic [USERW-1:0]       AXIS_S_TUSER,
  input  logic [DESTW-1:0]       AXIS_S_TDEST,
  output logic                   AXIS_M_TVALID,
  input  logic                   AXIS_M_TREADY,
  output logic [DATAW*RATIO-1:0] AXIS_M_TDATA,
  output logic [RATIO-1:0]       AXIS_M_TKEEP,
  output logic                   AXIS_M_TLAST,
  output logic [IDW-1:0]         AXIS_M_TID,
  output logic [USERW-1:0]       AXIS_M_TUSER,
  output logic [DESTW-1:0]       AXIS_M_TDEST,
  output logic                   SIDEBAND_ERR
);

  localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;

  // Assembly state
  logic [RATIO-1:0][DATAW-1:0] buf_q;
  logic [RATIO-1:0]            keep_q;
  logic [CW-1:0]               cnt_q;
  logic [IDW-1:0]              sid_q;
  logic [DESTW-1:0]            sdest_q;

  // Output register
  logic                        m_valid_q;
  logic [DATAW*RATIO-1:0]      m_data_q;
  logic [RATIO-1:0]            m_keep_q;
  logic                        m_last_q;
  logic [IDW-1:0]              m_id_q;
  logic [USERW-1:0]            m_user_q;
  logic [DESTW-1:0]            m_dest_q;
  logic                        err_q;

  // Next-state helpers
  logic [RATIO-1:0][DATAW-1:0] word_d;
  logic [RATIO-1:0]            keep_d;
  logic                        s_hs;
  logic                        first;
  logic                        complete;
  logic                        mismatch;
  logic [IDW-1:0]              word_id;
  logic [DESTW-1:0]            word_dest;

  // Gated by RST_N so the input side is held off while reset is asserted.
  assign AXIS_S_TREADY = RST_N && (!m_valid_q || AXIS_M_TREADY);

  always_comb begin
    s_hs      = AXIS_S_TVALID && AXIS_S_TREADY;
    first     = (cnt_q == '0);
    complete  = (cnt_q == CW'(RATIO - 1)) || AXIS_S_TLAST;
    mismatch  = (AXIS_S_TID != sid_q) || (AXIS_S_TDEST != sdest_q);
    // The first beat of a word supplies its own sideband; later beats use the captured copy.
    word_id   = first ? AXIS_S_TID : sid_q;
    word_dest = first ? AXIS_S_TDEST : sdest_q;
    word_d         = buf_q;
    word_d[cnt_q]  = AXIS_S_TDATA;
    keep_d         = keep_q;
    keep_d[cnt_q]  = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_q     <= '0;
      keep_q    <= '0;
      cnt_q     <= '0;
      sid_q     <= '0;
      sdest_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
      m_user_q  <= '0;
      m_dest_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= s_hs && !first && mismatch;

      if (s_hs) begin
        if (first) begin
          sid_q   <= AXIS_S_TID;
          sdest_q <= AXIS_S_TDEST;
        end
        if (complete) begin
          // Buffer is cleared here so lanes beyond a short word read back as zero.
          buf_q    <= '0;
          keep_q   <= '0;
          cnt_q    <= '0;
          m_data_q <= word_d;
          m_keep_q <= keep_d;
          m_last_q <= AXIS_S_TLAST;
          m_id_q   <= word_id;
          m_user_q <= AXIS_S_TUSER;
          m_dest_q <= word_dest;
        end else begin
          buf_q  <= word_d;
          keep_q <= keep_d;
          cnt_q  <= cnt_q + 1'b1;
        end
      end

      if (s_hs && complete) begin
        m_valid_q <= 1'b1;
      end else if (m_valid_q && AXIS_M_TREADY) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign AXIS_M_TVALID = m_valid_q;
  assign AXIS_M_TDATA  = m_data_q;
  assign AXIS_M_TKEEP  = m_keep_q;
  assign AXIS_M_TLAST  = m_last_q;
  assign AXIS_M_TID    = m_id_q;
  assign AXIS_M_TUSER  = m_user_q;
  assign AXIS_M_TDEST  = m_dest_q;
  assign SIDEBAND_ERR  = err_q;

endmodule

// File: doc/axis_beat_packer.md
Name: axis_beat_packer

Overview:
- AXI-Stream width upsizer. Sits directly downstream of the registered AXI-Stream pass-through stage in the MLP controller.
- Packs RATIO consecutive DATAW-bit beats into one DATAW*RATIO-bit word for the wide MLP operand path.
- Flushes a partial word on TLAST and marks its valid lanes in TKEEP.
- Registered output; full throughput when downstream is always ready.

Parameters:
- DATAW, 32, input beat data width
- RATIO, 4, beats per output word (power of two, 2..16)
- IDW, 4, TID width
- USERW, 4, TUSER width
- DESTW, 4, TDEST width

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- AXIS_S_TVALID  in  1  input beat valid
- AXIS_S_TREADY  out  1  input beat accepted when high with TVALID
- AXIS_S_TDATA  in  DATAW  input beat data
- AXIS_S_TLAST  in  1  last beat of packet
- AXIS_S_TID  in  IDW  stream ID
- AXIS_S_TUSER  in  USERW  user sideband
- AXIS_S_TDEST  in  DESTW  destination
- AXIS_M_TVALID  out  1  packed word valid
- AXIS_M_TREADY  in  1  downstream ready
- AXIS_M_TDATA  out  DATAW*RATIO  packed word, beat k in bits [k*DATAW +: DATAW]
- AXIS_M_TKEEP  out  RATIO  bit k high = lane k holds a received beat
- AXIS_M_TLAST  out  1  word ends a packet
- AXIS_M_TID  out  IDW  TID of first beat of word
- AXIS_M_TUSER  out  USERW  TUSER of last beat of word
- AXIS_M_TDEST  out  DESTW  TDEST of first beat of word
- SIDEBAND_ERR  out  1  one-cycle pulse: TID/TDEST changed inside a word

Behaviour:
- Reset is asynchronous, active-low. All outputs and internal state clear to 0: TVALID, TDATA, TKEEP, TLAST, TID, TUSER, TDEST, SIDEBAND_ERR, lane counter, assembly buffer. AXIS_S_TREADY is 0 during reset and 1 in the first cycle after release.
- Reset mid-word or mid-output discards all held data. No partial word is emitted.
- Internal state:
  - assembly buffer (RATIO lanes) plus keep mask
  - lane counter cnt, 0..RATIO-1
  - one output register
- AXIS_S_TREADY = !AXIS_M_TVALID || AXIS_M_TREADY. This is combinational on output state and never depends on AXIS_S_TVALID.
- On an input handshake:
  - Write the beat into lane cnt and set keep bit cnt.
  - If cnt==0, capture TID and TDEST as word sideband.
  - If cnt!=0 and TID or TDEST differs from the captured value, pulse SIDEBAND_ERR next cycle. The beat is still packed and the captured sideband is retained.
- Completing beat (cnt==RATIO-1 or TLAST=1):
  - Next cycle, the output register loads the assembled word: TKEEP = keep mask, TLAST = beat TLAST, TUSER = beat TUSER.
  - AXIS_M_TVALID goes 1.
  - cnt returns to 0 and the keep mask clears.
- Non-completing beat: cnt increments and there is no output change.
- Latency: one cycle from completing-beat handshake to AXIS_M_TVALID.
- Output register holds all fields stable while TVALID=1 and TREADY=0.
- On output handshake with no new completing beat, AXIS_M_TVALID drops to 0 next cycle.
- Simultaneous output handshake and completing input beat: the register reloads with the new word and TVALID stays 1. Throughput is one word per RATIO input cycles with no bubbles.
- TLAST on the first beat gives TKEEP=1 (single lane). Unused lanes of TDATA are 0.
- A packet of exactly RATIO beats produces a single word with TLAST=1 and TKEEP all ones. No empty trailing word is emitted.
- There is no timeout flush: a partial word without TLAST waits indefinitely.

Test Plan:
- Reset release, idle: all outputs 0 and AXIS_S_TREADY=1. Drive beats 0x11,0x22,0x33,0x44 (TLAST on 4th), M_TREADY=1 → one cycle after the 4th handshake, TDATA=0x00000044_00000033_00000022_00000011, TKEEP=4'b1111, TLAST=1, TVALID for 1 cycle.
- Packet of 6 beats 1..6 with TLAST on 6th → word0 {4,3,2,1} with TKEEP=1111, TLAST=0; word1 lanes {0,0,6,5} with TKEEP=0011, TLAST=1.
- Hold M_TREADY=0 after word0 completes, stream continues → S_TREADY drops once word0 is pending. Word0 is held stable with no beat loss. Release TREADY → word1 follows with correct data.
- Continuous 32-beat stream, M_TREADY=1 → 8 words on consecutive RATIO-cycle boundaries, S_TREADY never low.
- TID=1 on beat 0, TID=2 on beat 2 → SIDEBAND_ERR pulses 1 cycle and the output word carries TID=1.
- Assert RST_N=0 after 2 beats of a word → outputs 0 immediately. Post-reset 4-beat packet emits only the new data with TKEEP=1111.
